// File: rtl/clkdiv_multi.sv
// clkdiv_multi: multi-channel runtime-programmable clock divider.
// Each channel produces a 50% duty square wave of period 2*half[i] plus a
// one-cycle tick on every output transition. New half-periods are written
// through a valid/ready port and held in a shadow register until the
// channel reaches a half-period boundary, so outputs never see a runt pulse.
// Optional feature: define CLKDIV_SYNC_EN to add the sync input, which
// realigns every channel to phase 0 and applies all pending writes.
module clkdiv_multi #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 32,
    parameter int DEFAULT_HALF = 50000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CHANNELS-1:0]         en,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [$clog2(CHANNELS)-1:0] cfg_sel,
    input  logic [WIDTH-1:0]            cfg_half,
    output logic [CHANNELS-1:0]         clk_out,
    output logic [CHANNELS-1:0]         tick
`ifdef CLKDIV_SYNC_EN
    ,
    input  logic                        sync
`endif
);

    localparam int SEL_W = $clog2(CHANNELS);

    logic                sync_pulse;
    logic [CHANNELS-1:0] pending;
    logic                cfg_accept;

`ifdef CLKDIV_SYNC_EN
    assign sync_pulse = sync;
`else
    assign sync_pulse = 1'b0;
`endif

    assign cfg_accept = cfg_valid & cfg_ready;

    // Ready reflects the selected channel's free shadow slot; out-of-range selects are never ready.
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_sel == SEL_W'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] half_q;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] shadow_q;
        logic             pend_q;
        logic             clk_q;
        logic             tick_q;
        logic             running;
        logic             wrap;
        logic             boundary;
        logic             load;

        assign running  = en[g] && (half_q != '0);
        assign wrap     = running && (cnt_q == half_q - WIDTH'(1));
        // A stopped channel has no phase to protect, so every edge is a safe point.
        assign boundary = wrap || !running;
        assign load     = cfg_accept && (cfg_sel == SEL_W'(g));

        // Per-channel counter, output toggle, and shadow-to-active half-period transfer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                half_q   <= WIDTH'(DEFAULT_HALF);
                cnt_q    <= '0;
                shadow_q <= '0;
                pend_q   <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                if (sync_pulse) begin
                    cnt_q  <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (pend_q) begin
                        half_q <= shadow_q;
                        pend_q <= 1'b0;
                    end
                end else begin
                    if (wrap) begin
                        clk_q  <= ~clk_q;
                        tick_q <= 1'b1;
                    end else begin
                        tick_q <= 1'b0;
                    end

                    if (boundary && pend_q) begin
                        half_q <= shadow_q;
                        cnt_q  <= '0;
                        pend_q <= 1'b0;
                    end else if (wrap) begin
                        cnt_q <= '0;
                    end else if (running) begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end

                // Accept only happens with pend_q clear, so it never collides with an apply.
                if (load) begin
                    shadow_q <= cfg_half;
                    pend_q   <= 1'b1;
                end
            end
        end

        assign clk_out[g] = clk_q;
        assign tick[g]    = tick_q;
        assign pending[g] = pend_q;
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi (CHANNELS=4, WIDTH=16, DEFAULT_HALF=3).
// The reference model tracks cycles remaining in each half-period.
module tb_clkdiv_multi;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int DH = 3;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] en = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [SW-1:0] cfg_sel = '0;
    logic [W-1:0]  cfg_half = '0;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic          sync = 1'b0;

    always #5 clk = ~clk;

    clkdiv_multi #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .DEFAULT_HALF(DH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_sel  (cfg_sel),
        .cfg_half (cfg_half),
        .clk_out  (clk_out),
        .tick     (tick)
`ifdef CLKDIV_SYNC_EN
        ,
        .sync     (sync)
`endif
    );

    int total = 0;
    int bad   = 0;

    int m_half[CH];
    int m_rem[CH];
    int m_shadow[CH];
    bit m_clk[CH];
    bit m_tick[CH];
    bit m_pend[CH];

    typedef struct {
        logic [CH-1:0] en;
        logic [CH-1:0] exp_clk;
        logic [CH-1:0] exp_tick;
    } vec_t;

    vec_t vec[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_half[c] = DH; m_rem[c] = DH; m_shadow[c] = 0;
            m_clk[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
        end
    endfunction

    function automatic logic model_ready();
        return !m_pend[cfg_sel];
    endfunction

    function automatic logic [CH-1:0] model_clk();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_clk[c];
        return v;
    endfunction

    function automatic logic [CH-1:0] model_tick();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_tick[c];
        return v;
    endfunction

    // One rising edge of the spec's behaviour, using the currently driven inputs.
    function automatic void model_step();
        bit acc;
        bit run;
        bit bnd;
        acc = cfg_valid && !m_pend[cfg_sel];
        for (int c = 0; c < CH; c++) begin
            if (sync) begin
                m_clk[c] = 0; m_tick[c] = 0;
                if (m_pend[c]) begin m_half[c] = m_shadow[c]; m_pend[c] = 0; end
                m_rem[c] = m_half[c];
            end else begin
                bnd = 0;
                run = en[c] && (m_half[c] != 0);
                if (run) begin
                    if (m_rem[c] == 1) begin
                        m_clk[c] = !m_clk[c]; m_tick[c] = 1; m_rem[c] = m_half[c]; bnd = 1;
                    end else begin
                        m_rem[c]--; m_tick[c] = 0;
                    end
                end else begin
                    m_tick[c] = 0; bnd = 1;
                end
                if (bnd && m_pend[c]) begin
                    m_half[c] = m_shadow[c]; m_pend[c] = 0; m_rem[c] = m_half[c];
                end
            end
        end
        if (acc) begin
            m_shadow[cfg_sel] = int'(cfg_half);
            m_pend[cfg_sel] = 1;
        end
    endfunction

    // Entered and left at posedge+1; inputs must already be driven.
    task automatic cycle();
        @(negedge clk);
        check("cfg_ready", {31'd0, cfg_ready}, {31'd0, model_ready()});
        @(posedge clk);
        model_step();
        #1;
        check("clk_out", {28'd0, clk_out}, {28'd0, model_clk()});
        check("tick", {28'd0, tick}, {28'd0, model_tick()});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        en = '0; cfg_valid = 1'b0; cfg_sel = '0; cfg_half = '0; sync = 1'b0;
        model_reset();
        #1;
        check("reset clk_out", {28'd0, clk_out}, 32'd0);
        check("reset tick", {28'd0, tick}, 32'd0);
        check("reset ready", {31'd0, cfg_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic write_cfg(input int sel, input int h);
        cfg_valid = 1'b1; cfg_sel = SW'(sel); cfg_half = W'(h);
        cycle();
        cfg_valid = 1'b0;
    endtask

    logic [31:0] tmask;
    logic [31:0] rmask;

    initial begin
        vec[0] = '{4'hF, 4'h0, 4'h0};
        vec[1] = '{4'hF, 4'h0, 4'h0};
        vec[2] = '{4'hF, 4'hF, 4'hF};
        vec[3] = '{4'hF, 4'hF, 4'h0};
        vec[4] = '{4'hF, 4'hF, 4'h0};
        vec[5] = '{4'hF, 4'h0, 4'hF};
        vec[6] = '{4'hF, 4'h0, 4'h0};

        // Reset release with all channels enabled: rise on edge 3, fall on edge 6.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            en = vec[i].en;
            cycle();
            check("tbl clk_out", {28'd0, clk_out}, {28'd0, vec[i].exp_clk});
            check("tbl tick", {28'd0, tick}, {28'd0, vec[i].exp_tick});
        end

        // Channel 1 at half=4, rewrite to 2 while cnt=1.
        do_reset();
        write_cfg(1, 4);
        cycle();
        en = 4'b0010;
        tmask = '0; rmask = '0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 2) begin cfg_valid = 1'b1; cfg_sel = 2'd1; cfg_half = 16'd2; end
            cycle();
            cfg_valid = 1'b0;
            tmask[k] = tick[1];
            rmask[k] = ~cfg_ready;
        end
        check("seqA ticks", tmask, (32'd1 << 4) | (32'd1 << 6) | (32'd1 << 8));
        check("seqA ready_low", rmask, (32'd1 << 2) | (32'd1 << 3));

        // Write accepted on the wrap edge is deferred to the following boundary.
        do_reset();
        en = 4'b0001;
        tmask = '0; rmask = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) begin cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_half = 16'd5; end
            cycle();
            cfg_valid = 1'b0;
            tmask[k] = tick[0];
            rmask[k] = ~cfg_ready;
        end
        check("seqB ticks", tmask, (32'd1 << 3) | (32'd1 << 6) | (32'd1 << 11));
        check("seqB ready_low", rmask, (32'd1 << 3) | (32'd1 << 4) | (32'd1 << 5));

        // Channel 2 frozen for 5 edges, then resumed; then a write while disabled.
        do_reset();
        en = 4'hF;
        tmask = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) en[2] = 1'b0;
            if (k == 7) en[2] = 1'b1;
            cycle();
            tmask[k] = tick[2];
        end
        check("seqC freeze ticks", tmask, 32'd1 << 8);
        check("seqC clk held", {31'd0, clk_out[2]}, 32'd1);
        en[2] = 1'b0;
        write_cfg(2, 2);
        check("seqC ready after accept", {31'd0, cfg_ready}, 32'd0);
        cycle();
        check("seqC ready after apply", {31'd0, cfg_ready}, 32'd1);
        en[2] = 1'b1;
        tmask = '0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            tmask[k] = tick[2];
        end
        check("seqC new half ticks", tmask, (32'd1 << 2) | (32'd1 << 4));
        check("seqC clk end", {31'd0, clk_out[2]}, 32'd1);

        // half=1 toggles every cycle; then half=0 stops the channel.
        do_reset();
        write_cfg(3, 1);
        cycle();
        en = 4'b1000;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check("seqD tick high", {31'd0, tick[3]}, 32'd1);
            check("seqD toggle", {31'd0, clk_out[3]}, 32'(k % 2));
        end
        write_cfg(3, 0);
        cycle();
        for (int k = 1; k <= 3; k++) begin
            cycle();
            check("seqD stopped tick", {31'd0, tick[3]}, 32'd0);
            check("seqD stopped clk", {31'd0, clk_out[3]}, 32'd0);
        end

`ifdef CLKDIV_SYNC_EN
        // Sync pulse with channels at mixed phases.
        do_reset();
        en = 4'hF;
        write_cfg(1, 5);
        write_cfg(2, 2);
        for (int k = 0; k < 7; k++) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        check("sync clk_out", {28'd0, clk_out}, 32'd0);
        check("sync tick", {28'd0, tick}, 32'd0);
        for (int k = 0; k < 12; k++) cycle();
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < CH; c++) en[c] = ($urandom_range(0, 9) < 8);
            cfg_valid = $urandom_range(0, 1) == 1;
            cfg_sel   = SW'($urandom_range(0, CH - 1));
            cfg_half  = W'($urandom_range(0, 6));
`ifdef CLKDIV_SYNC_EN
            sync = ($urandom_range(0, 99) == 0);
`endif
            cycle();
        end
        cfg_valid = 1'b0;
        sync = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
